// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================
// mem_stage_ctrl_if : AXI4-Lite data-memory bus (master/slave views)
// Rev 1.0
// ============================================================
interface mem_stage_ctrl_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================
// mem_stage_ctrl : M-stage load/store controller on an AXI4-Lite master
// Rev 1.0
// ============================================================
module mem_stage_ctrl (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [3:0]  regM_i_mem_rw,
  input  wire logic [31:0] regM_i_valE,
  input  wire logic [31:0] regM_i_valB,
  output logic             mem_o_stall,
  output logic             mem_o_done,
  output logic [31:0]      mem_o_rdata,
  output logic             mem_o_err,
  mem_stage_ctrl_if.master io_master
);

  localparam logic [3:0] c_lb  = 4'd1;
  localparam logic [3:0] c_lh  = 4'd2;
  localparam logic [3:0] c_lw  = 4'd3;
  localparam logic [3:0] c_lbu = 4'd4;
  localparam logic [3:0] c_lhu = 4'd5;
  localparam logic [3:0] c_sb  = 4'd6;
  localparam logic [3:0] c_sh  = 4'd7;
  localparam logic [3:0] c_sw  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_code;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic        r_rready;
  logic        r_awvalid;
  logic [31:0] r_awaddr;
  logic        r_wvalid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bready;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_valid;
  logic        w_misaligned;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic        w_accept;

  // Request decode, misalignment detection and store lane steering.
  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_wdata      = '0;
    w_wstrb      = '0;
    case (regM_i_mem_rw)
      c_lb, c_lbu: w_is_load = 1'b1;
      c_lh, c_lhu: begin
        w_is_load    = 1'b1;
        w_misaligned = regM_i_valE[0];
      end
      c_lw: begin
        w_is_load    = 1'b1;
        w_misaligned = |regM_i_valE[1:0];
      end
      c_sb: begin
        w_is_store = 1'b1;
        w_wdata    = {4{regM_i_valB[7:0]}};
        w_wstrb    = 4'b0001 << regM_i_valE[1:0];
      end
      c_sh: begin
        w_is_store   = 1'b1;
        w_misaligned = regM_i_valE[0];
        w_wdata      = {2{regM_i_valB[15:0]}};
        w_wstrb      = 4'b0011 << regM_i_valE[1:0];
      end
      c_sw: begin
        w_is_store   = 1'b1;
        w_misaligned = |regM_i_valE[1:0];
        w_wdata      = regM_i_valB;
        w_wstrb      = 4'hF;
      end
      default: ;
    endcase
  end

  assign w_valid  = w_is_load | w_is_store;
  assign w_accept = (r_state == S_IDLE) && w_valid;

  always_comb begin
    w_shifted   = io_master.rdata >> {r_addr_lo, 3'b000};
    w_load_data = '0;
    case (r_code)
      c_lb:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      c_lh:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      c_lbu:   w_load_data = {24'd0, w_shifted[7:0]};
      c_lhu:   w_load_data = {16'd0, w_shifted[15:0]};
      c_lw:    w_load_data = w_shifted;
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    mem_o_stall  = 1'b0;
    mem_o_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_o_stall = w_valid;
        if (w_valid) begin
          if (w_misaligned)   w_state_next = S_DONE;
          else if (w_is_load) w_state_next = S_RD_ADDR;
          else                w_state_next = S_WR_REQ;
        end
      end
      S_RD_ADDR: begin
        mem_o_stall = 1'b1;
        if (io_master.arready) w_state_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        mem_o_stall = 1'b1;
        if (io_master.rvalid) w_state_next = S_DONE;
      end
      S_WR_REQ: begin
        mem_o_stall = 1'b1;
        // A channel whose valid has already dropped has completed its handshake.
        if ((!r_awvalid || io_master.awready) && (!r_wvalid || io_master.wready))
          w_state_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        mem_o_stall = 1'b1;
        if (io_master.bvalid) w_state_next = S_DONE;
      end
      S_DONE: begin
        mem_o_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_addr_lo <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bready  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_arvalid <= (w_state_next == S_RD_ADDR);
      r_rready  <= (w_state_next == S_RD_DATA);
      r_bready  <= (w_state_next == S_WR_RESP);
      if (w_accept) begin
        r_code    <= regM_i_mem_rw;
        r_addr_lo <= regM_i_valE[1:0];
        r_rdata   <= '0;
        r_err     <= w_misaligned;
        if (w_is_load && !w_misaligned) r_araddr <= regM_i_valE;
        if (w_is_store && !w_misaligned) begin
          r_awaddr  <= regM_i_valE;
          r_wdata   <= w_wdata;
          r_wstrb   <= w_wstrb;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
        end
      end
      if (r_state == S_WR_REQ) begin
        if (io_master.awready) r_awvalid <= 1'b0;
        if (io_master.wready)  r_wvalid  <= 1'b0;
      end
      if ((r_state == S_RD_DATA) && io_master.rvalid) begin
        r_rdata <= w_load_data;
        r_err   <= |io_master.rresp;
      end
      if ((r_state == S_WR_RESP) && io_master.bvalid)
        r_err <= |io_master.bresp;
    end
  end

  assign io_master.arvalid = r_arvalid;
  assign io_master.araddr  = r_araddr;
  assign io_master.rready  = r_rready;
  assign io_master.awvalid = r_awvalid;
  assign io_master.awaddr  = r_awaddr;
  assign io_master.wvalid  = r_wvalid;
  assign io_master.wdata   = r_wdata;
  assign io_master.wstrb   = r_wstrb;
  assign io_master.bready  = r_bready;
  assign mem_o_rdata       = r_rdata;
  assign mem_o_err         = r_err;

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the five-stage pipeline. It reads the access request held in the M-stage pipeline register, runs the matching AXI4-Lite read or write on the data-memory master port, and stalls the F/D/E/M pipeline registers until the access completes. It also performs store byte-lane steering and load sign/zero extension, and hands the final load data and an error flag to the W-stage register.

## Interface
Parameters: none.
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- regM_i_mem_rw  in  4  access code: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw; 9–15 treated as none
- regM_i_valE  in  32  byte address
- regM_i_valB  in  32  store source data (low bits used for sb/sh)
- mem_o_stall  out  1  hold F/D/E/M registers and insert a bubble into W
- mem_o_done  out  1  one-cycle pulse: access complete, M instruction advances
- mem_o_rdata  out  32  extended load data, valid while mem_o_done=1
- mem_o_err  out  1  misaligned access or non-OKAY response, valid while mem_o_done=1
- io_master_arvalid/arready/araddr[31:0]  out/in/out  AXI4-Lite read address channel
- io_master_rvalid/rready/rdata[31:0]/rresp[1:0]  in/out/in/in  read data channel
- io_master_awvalid/awready/awaddr[31:0]  out/in/out  write address channel
- io_master_wvalid/wready/wdata[31:0]/wstrb[3:0]  out/in/out/out  write data channel
- io_master_bvalid/bready/bresp[1:0]  in/out/in  write response channel

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE with code none: mem_o_stall=0 and no bus activity.
- IDLE with a valid access:
  - Misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]≠0) goes directly to DONE with err=1 and no bus transaction.
  - An aligned load goes to RD_ADDR; an aligned store goes to WR_REQ.
  - The address, the data and the decoded access code are latched in the same cycle.
- RD_ADDR: arvalid=1, araddr = latched address. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture the extended data and err=(rresp≠0), then go to DONE.
- WR_REQ: awvalid and wvalid rise together. Each channel drops independently after its own handshake. When both handshakes are done (in the same or different cycles), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, err=(bresp≠0), then go to DONE.
- DONE: mem_o_done=1 and mem_o_stall=0. Always go to IDLE next cycle; the completed instruction leaves M on this edge.
- Store steering, with sh = addr[1:0]:
  - sb: wdata={4{valB[7:0]}}, wstrb=4'b0001<<sh.
  - sh: wdata={2{valB[15:0]}}, wstrb=4'b0011<<sh.
  - sw: wdata=valB, wstrb=4'hF.
- Load extraction: shift rdata right by 8×addr[1:0], then:
  - lb/lh: sign-extend from bit 7/15.
  - lbu/lhu: zero-extend.
  - lw: pass through.
  - Stores: rdata=0.
- All AXI outputs are registered. Once asserted, address, data and strobe stay stable until the handshake completes.

## Timing
- mem_o_stall is combinational: 1 in IDLE when the code is valid, and 1 in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
- Minimum load latency: IDLE, RD_ADDR (arready=1), RD_DATA (rvalid=1), DONE = 4 cycles from the access appearing in M until done. A store with immediate readiness takes the same 4 cycles.
- Misaligned access: 2 cycles (IDLE then DONE).
- Reset values: state IDLE; all valid and ready outputs 0; araddr/awaddr/wdata/wstrb = 0; mem_o_rdata=0, mem_o_err=0, mem_o_done=0.
- Reset mid-transaction: all valids drop on the next edge, the transaction is abandoned, and no done pulse is produced.
- rvalid or bvalid arriving before its handshake state is ignored; rready and bready are 0 outside RD_DATA and WR_RESP.
- Back-to-back accesses: the next access is recognised in the IDLE cycle that follows DONE, never in DONE itself. No double issue is possible.

## Test plan
- lw at 0x8000_0004, arready and rvalid immediate, rdata=0xDEAD_BEEF → done on cycle 4, rdata=0xDEADBEEF, err=0, stall high for exactly 3 cycles.
- lb and lbu at 0x8000_0003, rdata=0x80xx_xxxx → lb gives 0xFFFF_FF80 and lbu gives 0x0000_0080.
- sb at 0x8000_0002, valB=0x1234_56AB → wdata=0xABABABAB, wstrb=4'b0100. Also with awready arriving 3 cycles before wready: each valid drops on its own handshake and WR_RESP is entered only after both.
- sw at 0x8000_0001 → no AW/W/AR valid ever asserted; done on cycle 2 with err=1.
- lh with rresp=2'b10 and 5-cycle arready delay → stall held throughout, done with err=1, araddr stable while arvalid=1.
- rst asserted while in WR_REQ → next cycle awvalid=wvalid=0 and state IDLE; no done pulse; the following lw completes normally.
